booth_pp_accumulator: RTL



---
 rtl/booth_pkg.sv | 22 ++
 rtl/booth_row_align.sv | 24 ++
 rtl/booth_pp_accumulator.sv | 126 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Constants and types shared between the Booth encoder side and the
// partial-product accumulator of the 16x16 signed multiplier.
package booth_pkg;

   localparam int MCAND_W = 16;
   localparam int PP_W    = MCAND_W + 1;
   localparam int N_ROWS  = 8;
   localparam int PROD_W  = 32;
   localparam int IDX_W   = $clog2(N_ROWS);

   typedef struct packed {
      logic [PP_W-1:0] data;
      logic            neg;
   } pp_row_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } acc_state_e;

endpackage

// File: rtl/booth_row_align.sv
// Turns one Booth partial-product row into its PROD_W-wide addend: sign
// extension, shift by row weight (4^idx) and the +1 complement bit.
module booth_row_align #(
   parameter int PP_W   = booth_pkg::PP_W,
   parameter int PROD_W = booth_pkg::PROD_W,
   parameter int IDX_W  = booth_pkg::IDX_W
) (
   input  logic [PP_W-1:0]   pp_data,
   input  logic              pp_neg,
   input  logic [IDX_W-1:0]  idx,
   output logic [PROD_W-1:0] addend
);

   logic [PROD_W-1:0] sext;
   logic [IDX_W:0]    shamt;

   always_comb begin
      sext   = {{(PROD_W-PP_W){pp_data[PP_W-1]}}, pp_data};
      shamt  = {idx, 1'b0};
      // The neg bit completes the two's complement of a one's-complemented row.
      addend = (sext << shamt) + (PROD_W'(pp_neg) << shamt);
   end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Accumulates the radix-4 Booth rows of one multiply into a signed product
// and hands it downstream over a valid/ready handshake.
module booth_pp_accumulator #(
   parameter int N_ROWS = booth_pkg::N_ROWS,
   parameter int PP_W   = booth_pkg::PP_W,
   parameter int PROD_W = booth_pkg::PROD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pp_valid,
   output logic              pp_ready,
   input  logic [PP_W-1:0]   pp_data,
   input  logic              pp_neg,
   input  logic              pp_last,
   output logic              prod_valid,
   input  logic              prod_ready,
   output logic [PROD_W-1:0] prod_data,
   output logic              prod_err
);

   import booth_pkg::*;

   localparam int IW = $clog2(N_ROWS);
   localparam logic [IW-1:0] IDX_MAX = IW'(N_ROWS - 1);

   // Handshakes: a row moves on a clock edge where pp_valid && pp_ready, a
   // product moves where prod_valid && prod_ready. Both ready/valid outputs
   // come from flops only, never from the opposite side's inputs.

   acc_state_e        state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [PROD_W-1:0] acc_q, acc_d;
   logic              err_q, err_d;
   logic              ready_q, ready_d;

   logic              pp_fire;
   logic [PROD_W-1:0] addend;
   logic [PROD_W-1:0] acc_base;

   booth_row_align #(
      .PP_W  (PP_W),
      .PROD_W(PROD_W),
      .IDX_W (IW)
   ) u_align (
      .pp_data(pp_data),
      .pp_neg (pp_neg),
      .idx    (idx_q),
      .addend (addend)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      err_d    = err_q;
      pp_fire  = pp_valid && ready_q;
      acc_base = (state_q == ST_IDLE) ? '0 : acc_q;

      case (state_q)
         ST_IDLE: begin
            if (pp_fire) begin
               acc_d = acc_base + addend;
               if (pp_last) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_ACCUM;
                  idx_d   = IW'(1);
               end
            end
         end
         ST_ACCUM: begin
            if (pp_fire) begin
               acc_d = acc_base + addend;
               idx_d = idx_q + IW'(1);
               if (idx_q == IDX_MAX) begin
                  state_d = ST_DONE;
                  err_d   = !pp_last;
               end else if (pp_last) begin
                  // Short multiply: deliver the partial sum, flagged.
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (prod_ready) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               acc_d   = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            acc_d   = '0;
            err_d   = 1'b0;
         end
      endcase

      ready_d = (state_d != ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

   assign pp_ready   = ready_q;
   assign prod_valid = (state_q == ST_DONE);
   assign prod_data  = acc_q;
   assign prod_err   = err_q;

endmodule
